// File: rtl/cpu_control_unit.sv
// Control FSM for the 8-bit CPU: fetch/decode/execute sequencing with
// combinational datapath controls decoded from state, IR and CCR flags.
module cpu_control_unit #(
   parameter logic [7:0] LDA_IMM = 8'h10,
   parameter logic [7:0] LDA_DIR = 8'h11,
   parameter logic [7:0] LDB_IMM = 8'h12,
   parameter logic [7:0] LDB_DIR = 8'h13,
   parameter logic [7:0] STA_DIR = 8'h14,
   parameter logic [7:0] STB_DIR = 8'h15,
   parameter logic [7:0] ADD_AB  = 8'h20,
   parameter logic [7:0] SUB_AB  = 8'h21,
   parameter logic [7:0] AND_AB  = 8'h22,
   parameter logic [7:0] OR_AB   = 8'h23,
   parameter logic [7:0] INCA    = 8'h24,
   parameter logic [7:0] INCB    = 8'h25,
   parameter logic [7:0] DECA    = 8'h26,
   parameter logic [7:0] DECB    = 8'h27,
   parameter logic [7:0] BRA     = 8'h30,
   parameter logic [7:0] BNU     = 8'h31,
   parameter logic [7:0] BND     = 8'h32,
   parameter logic [7:0] BZU     = 8'h33,
   parameter logic [7:0] BZD     = 8'h34,
   parameter logic [7:0] BVU     = 8'h35,
   parameter logic [7:0] BVD     = 8'h36,
   parameter logic [7:0] BCU     = 8'h37,
   parameter logic [7:0] BCD     = 8'h38
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IR,
   input  logic [3:0] CCR_Result,
   output logic       IR_Load,
   output logic       MAR_Load,
   output logic       PC_Load,
   output logic       PC_Inc,
   output logic       A_Load,
   output logic       B_Load,
   output logic [2:0] ALU_Sel,
   output logic       CCR_Load,
   output logic [1:0] Bus1_Sel,
   output logic [1:0] Bus2_Sel,
   output logic       write
);

   typedef enum logic [3:0] {
      F0, F1, F2, D3,
      E0, E1, E2, E3, E4,
      EX_ALU,
      BT0, BT1, BT2,
      BNT
   } state_t;

   state_t state;

   logic       is_ld_imm, is_ld_dir, is_store, is_alu, is_branch;
   logic       dst_a, br_taken;
   logic [2:0] alu_sel;

   logic n_f, z_f, v_f, c_f;
   assign {n_f, z_f, v_f, c_f} = CCR_Result;

   always_comb begin
      is_ld_imm = (IR == LDA_IMM) || (IR == LDB_IMM);
      is_ld_dir = (IR == LDA_DIR) || (IR == LDB_DIR);
      is_store  = (IR == STA_DIR) || (IR == STB_DIR);
      dst_a     = (IR == LDA_IMM) || (IR == LDA_DIR) || (IR == STA_DIR);
      is_alu    = 1'b1;
      alu_sel   = 3'b000;
      case (IR)
         ADD_AB:      alu_sel = 3'b000;
         SUB_AB:      alu_sel = 3'b001;
         AND_AB:      alu_sel = 3'b010;
         OR_AB:       alu_sel = 3'b011;
         INCA, INCB:  alu_sel = 3'b100;
         DECA, DECB:  alu_sel = 3'b101;
         default:     is_alu  = 1'b0;
      endcase
      is_branch = 1'b1;
      br_taken  = 1'b0;
      case (IR)
         BRA:     br_taken = 1'b1;
         BNU:     br_taken = n_f;
         BND:     br_taken = ~n_f;
         BZU:     br_taken = z_f;
         BZD:     br_taken = ~z_f;
         BVU:     br_taken = v_f;
         BVD:     br_taken = ~v_f;
         BCU:     br_taken = c_f;
         BCD:     br_taken = ~c_f;
         default: is_branch = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= F0;
      end else begin
         case (state)
            F0: state <= F1;
            F1: state <= F2;
            F2: state <= D3;
            D3: begin
               if (is_ld_imm || is_ld_dir || is_store) state <= E0;
               else if (is_alu)                        state <= EX_ALU;
               else if (is_branch)                     state <= br_taken ? BT0 : BNT;
               else                                    state <= F0;
            end
            E0: state <= E1;
            E1: state <= E2;
            E2: state <= is_ld_imm ? F0 : E3;
            E3: state <= is_store ? F0 : E4;
            E4: state <= F0;
            BT0: state <= BT1;
            BT1: state <= BT2;
            default: state <= F0;
         endcase
      end
   end

   // Outputs are gated by reset directly so an abort suppresses write at once.
   always_comb begin
      IR_Load  = 1'b0;
      MAR_Load = 1'b0;
      PC_Load  = 1'b0;
      PC_Inc   = 1'b0;
      A_Load   = 1'b0;
      B_Load   = 1'b0;
      ALU_Sel  = 3'b000;
      CCR_Load = 1'b0;
      Bus1_Sel = 2'd0;
      Bus2_Sel = 2'd0;
      write    = 1'b0;
      if (!reset) begin
         case (state)
            F0, E0, BT0: begin
               Bus1_Sel = 2'd0;
               Bus2_Sel = 2'd1;
               MAR_Load = 1'b1;
            end
            F1, E1, BNT: PC_Inc = 1'b1;
            F2: begin
               Bus2_Sel = 2'd2;
               IR_Load  = 1'b1;
            end
            E2: begin
               Bus2_Sel = 2'd2;
               if (is_ld_imm) begin
                  A_Load = dst_a;
                  B_Load = ~dst_a;
               end else begin
                  MAR_Load = 1'b1;
               end
            end
            E3: begin
               if (is_store) begin
                  Bus1_Sel = dst_a ? 2'd1 : 2'd2;
                  write    = 1'b1;
               end
            end
            E4: begin
               Bus2_Sel = 2'd2;
               A_Load   = dst_a;
               B_Load   = ~dst_a;
            end
            EX_ALU: begin
               ALU_Sel  = alu_sel;
               Bus2_Sel = 2'd0;
               CCR_Load = 1'b1;
               Bus1_Sel = ((IR == INCA) || (IR == DECA)) ? 2'd1 : 2'd2;
               if ((IR == INCB) || (IR == DECB)) B_Load = 1'b1;
               else                              A_Load = 1'b1;
            end
            BT2: begin
               Bus2_Sel = 2'd2;
               PC_Load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
